// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle 16-bit memory port between the b16 cpu
// and one DMA requester.
//
// The cpu has no wait input. When DMA must take a cycle the cpu wants, the
// arbiter stalls the cpu by dropping cpu_run. Cycles the cpu leaves idle are
// given to DMA without stalling. A starvation timer (WAITMAX) gives a waiting
// DMA request priority. A burst limiter (BURST) then bounds how many
// consecutive cycles can be stolen from the cpu.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   run_in              debugger run request (cpu stalled when 0)
//   cpu_run             run input of the cpu
//   cpu_addr/rd/wr/dout cpu access request (wr = byte strobes {hi,lo})
//   cpu_din             read data to cpu (= mem_rdata)
//   dma_req             DMA request, held until dma_ack
//   dma_addr/rd/wr/wdata DMA access (rd ignored when wr != 0)
//   dma_ack             DMA access performed this cycle
//   dma_rdata           read data to DMA (= mem_rdata)
//   mem_addr/rd/wr/wdata memory port; mem_rdata returns in the same cycle
module mem_arbiter #(
    parameter int unsigned l       = 16,
    parameter int unsigned WAITMAX = 8,
    parameter int unsigned BURST   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run_in,
    output logic         cpu_run,
    input  logic [l-1:0] cpu_addr,
    input  logic         cpu_rd,
    input  logic [1:0]   cpu_wr,
    input  logic [l-1:0] cpu_dout,
    output logic [l-1:0] cpu_din,
    input  logic         dma_req,
    input  logic [l-1:0] dma_addr,
    input  logic         dma_rd,
    input  logic [1:0]   dma_wr,
    input  logic [l-1:0] dma_wdata,
    output logic         dma_ack,
    output logic [l-1:0] dma_rdata,
    output logic [l-1:0] mem_addr,
    output logic         mem_rd,
    output logic [1:0]   mem_wr,
    output logic [l-1:0] mem_wdata,
    input  logic [l-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        CPU_PRI   = 2'd0,
        DMA_PRI   = 2'd1,
        FORCE_CPU = 2'd2
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(WAITMAX - 1);
    localparam logic [7:0] BURST_LIM = 8'(BURST);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] burst_q, burst_d;

    logic cpu_need;
    logic free_cyc;
    logic stolen_cyc;
    logic grant_dma;

    // A cycle is "free" when the cpu does not need the port or is halted.
    // Only DMA_PRI may steal a cycle the cpu needs. FORCE_CPU is therefore
    // never stalling, because stealing is impossible outside DMA_PRI.
    always_comb begin
        cpu_need   = cpu_rd | (|cpu_wr);
        free_cyc   = dma_req & (~cpu_need | ~run_in);
        stolen_cyc = dma_req & ~free_cyc & (state_q == DMA_PRI);
        grant_dma  = ~reset & (free_cyc | stolen_cyc);
    end

    always_comb begin
        dma_ack   = grant_dma;
        cpu_run   = ~reset & run_in & ~stolen_cyc;
        cpu_din   = mem_rdata;
        dma_rdata = mem_rdata;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_dout;
        mem_rd    = cpu_rd & run_in;
        mem_wr    = cpu_wr & {2{run_in}};
        if (reset) begin
            // Constant drive keeps the memory port free of X during reset.
            mem_addr  = '0;
            mem_wdata = '0;
            mem_rd    = 1'b0;
            mem_wr    = '0;
        end else if (grant_dma) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_rd    = dma_rd & ~(|dma_wr);
            mem_wr    = dma_wr;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        unique case (state_q)
            CPU_PRI: begin
                if (dma_req && !grant_dma) begin
                    if (wait_q >= WAIT_LAST) begin
                        state_d = DMA_PRI;
                        wait_d  = '0;
                        burst_d = '0;
                    end else if (wait_q != 8'hFF) begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    wait_d = '0;
                end
            end
            DMA_PRI: begin
                if (!dma_req) begin
                    state_d = CPU_PRI;
                    wait_d  = '0;
                end else if (stolen_cyc) begin
                    burst_d = burst_q + 8'd1;
                    // Leave as the BURST-th steal completes so that exactly
                    // BURST cycles are stolen before the forced cpu cycle.
                    if (burst_d >= BURST_LIM) begin
                        state_d = FORCE_CPU;
                    end
                end
            end
            FORCE_CPU: begin
                state_d = CPU_PRI;
                wait_d  = '0;
            end
            default: begin
                state_d = CPU_PRI;
                wait_d  = '0;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CPU_PRI;
            wait_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int W  = 16;
    localparam int WM = 8;
    localparam int BU = 4;

    logic         clk = 1'b0;
    logic         reset, run_in, cpu_run;
    logic [W-1:0] cpu_addr, cpu_dout, cpu_din;
    logic         cpu_rd;
    logic [1:0]   cpu_wr;
    logic         dma_req, dma_rd, dma_ack;
    logic [W-1:0] dma_addr, dma_wdata, dma_rdata;
    logic [1:0]   dma_wr;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_rd;
    logic [1:0]   mem_wr;

    always #5 clk = ~clk;

    mem_arbiter #(.l(W), .WAITMAX(WM), .BURST(BU)) dut (
        .clk(clk), .reset(reset), .run_in(run_in), .cpu_run(cpu_run),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_rd(dma_rd),
        .dma_wr(dma_wr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model. m_waited counts consecutive unserved request cycles;
    // having waited WM cycles gives DMA priority until it either drops the
    // request or has taken BU cpu cycles, after which one cycle is reserved
    // for the cpu.
    int m_waited = 0;
    int m_stolen = 0;
    bit m_force  = 1'b0;

    logic         e_need, e_pri, e_free, e_steal, e_ack, e_run, e_mem_rd;
    logic [1:0]   e_mem_wr;
    logic [W-1:0] e_addr, e_wdata;

    assign e_need   = cpu_rd | (cpu_wr != 2'b00);
    assign e_pri    = !m_force && (m_waited >= WM);
    assign e_free   = dma_req && (!e_need || !run_in);
    assign e_steal  = dma_req && !e_free && e_pri;
    assign e_ack    = !reset && (e_free || e_steal);
    assign e_run    = !reset && run_in && !e_steal;
    assign e_mem_rd = reset ? 1'b0 : e_ack ? (dma_rd && dma_wr == 2'b00) : (cpu_rd && run_in);
    assign e_mem_wr = reset ? 2'b00 : e_ack ? dma_wr : (run_in ? cpu_wr : 2'b00);
    assign e_addr   = e_ack ? dma_addr : cpu_addr;
    assign e_wdata  = e_ack ? dma_wdata : cpu_dout;

    always @(posedge clk) begin
        if (reset) begin
            m_waited <= 0; m_stolen <= 0; m_force <= 1'b0;
        end else if (m_force) begin
            m_force <= 1'b0; m_waited <= 0;
        end else if (e_pri) begin
            if (!dma_req) begin
                m_waited <= 0; m_stolen <= 0;
            end else if (e_steal) begin
                if (m_stolen + 1 == BU) begin
                    m_stolen <= 0; m_waited <= 0; m_force <= 1'b1;
                end else begin
                    m_stolen <= m_stolen + 1;
                end
            end
        end else if (dma_req && !e_ack) begin
            m_waited <= m_waited + 1;
        end else begin
            m_waited <= 0;
        end
    end

    task automatic test_reset;
        reset = 1'b1; run_in = 1'b1; cpu_rd = 1'b1; dma_req = 1'b1; dma_rd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (dma_ack !== 1'b0 || cpu_run !== 1'b0) begin
                n_bad++; $display("FAIL reset_ctrl c=%0d got ack=%b run=%b want 0 0", c, dma_ack, cpu_run);
            end
            n_cmp++;
            if (mem_rd !== 1'b0 || mem_wr !== 2'b00) begin
                n_bad++; $display("FAIL reset_mem c=%0d got rd=%b wr=%b want 0 00", c, mem_rd, mem_wr);
            end
            n_cmp++;
            if ($isunknown(mem_addr) || $isunknown(mem_wdata)) begin
                n_bad++; $display("FAIL reset_noX got addr=%h wdata=%h want no X", mem_addr, mem_wdata);
            end
            @(negedge clk);
        end
        reset = 1'b0; dma_req = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic test_cpu_only;
        for (int c = 0; c < 10; c++) begin
            cpu_rd = 1'b1; cpu_addr = 16'($urandom); mem_rdata = 16'($urandom);
            #1;
            n_cmp++;
            if (cpu_run !== 1'b1 || dma_ack !== 1'b0 || mem_rd !== 1'b1) begin
                n_bad++; $display("FAIL cpu_only_ctrl got run=%b ack=%b rd=%b want 1 0 1", cpu_run, dma_ack, mem_rd);
            end
            n_cmp++;
            if (mem_addr !== cpu_addr || cpu_din !== mem_rdata) begin
                n_bad++; $display("FAIL cpu_only_data got addr=%h din=%h want %h %h", mem_addr, cpu_din, cpu_addr, mem_rdata);
            end
            @(negedge clk);
        end
        cpu_rd = 1'b0;
    endtask

    task automatic test_free_dma;
        logic acked = 1'b0;
        dma_addr = 16'h0100; dma_wdata = 16'hBEEF; dma_wr = 2'b11; dma_rd = 1'b0;
        for (int c = 0; c < 4; c++) begin
            logic want_ack;
            dma_req = !acked;
            cpu_rd = (c % 2 == 0); cpu_addr = 16'($urandom);
            want_ack = (c == 1);
            #1;
            n_cmp++;
            if (dma_ack !== want_ack || cpu_run !== 1'b1) begin
                n_bad++; $display("FAIL free_ack c=%0d got ack=%b run=%b want %b 1", c, dma_ack, cpu_run, want_ack);
            end
            if (want_ack) begin
                n_cmp++;
                if (mem_wr !== 2'b11 || mem_addr !== 16'h0100 || mem_wdata !== 16'hBEEF) begin
                    n_bad++; $display("FAIL free_write got wr=%b addr=%h data=%h want 11 0100 beef", mem_wr, mem_addr, mem_wdata);
                end
                acked = 1'b1;
            end else begin
                n_cmp++;
                if (mem_addr !== cpu_addr) begin
                    n_bad++; $display("FAIL free_cpu_addr c=%0d got %h want %h", c, mem_addr, cpu_addr);
                end
            end
            @(negedge clk);
        end
        dma_req = 1'b0; dma_wr = 2'b00; cpu_rd = 1'b0;
    endtask

    task automatic test_starvation;
        int acks = 0;
        dma_rd = 1'b1; dma_wr = 2'b00; dma_addr = 16'($urandom);
        for (int c = 1; c <= 24; c++) begin
            logic want_ack;
            cpu_rd = 1'b1; cpu_addr = 16'($urandom);
            dma_req = (acks < 6);
            want_ack = (c >= 9 && c <= 12) || c == 22 || c == 23;
            #1;
            n_cmp++;
            if (dma_ack !== want_ack || cpu_run !== !want_ack) begin
                n_bad++; $display("FAIL starve c=%0d got ack=%b run=%b want %b %b", c, dma_ack, cpu_run, want_ack, !want_ack);
            end
            if (want_ack) begin
                n_cmp++;
                if (mem_addr !== dma_addr || mem_rd !== 1'b1 || mem_wr !== 2'b00) begin
                    n_bad++; $display("FAIL starve_mem c=%0d got addr=%h rd=%b wr=%b want %h 1 00", c, mem_addr, mem_rd, mem_wr, dma_addr);
                end
                acks++;
                dma_addr = 16'($urandom);
            end
            @(negedge clk);
        end
        dma_req = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic test_run_off;
        dma_rd = 1'b1; dma_wr = 2'b00; cpu_rd = 1'b1; dma_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            #1;
            n_cmp++;
            if (dma_ack !== (c >= 9)) begin
                n_bad++; $display("FAIL runoff_pre c=%0d got ack=%b want %b", c, dma_ack, (c >= 9));
            end
            @(negedge clk);
        end
        run_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            dma_addr = 16'($urandom); dma_rd = 1'($urandom); dma_wr = 2'($urandom);
            cpu_addr = 16'($urandom); cpu_wr = 2'($urandom);
            #1;
            n_cmp++;
            if (dma_ack !== 1'b1 || cpu_run !== 1'b0) begin
                n_bad++; $display("FAIL runoff_ack c=%0d got ack=%b run=%b want 1 0", c, dma_ack, cpu_run);
            end
            n_cmp++;
            if (mem_rd !== (dma_rd && dma_wr == 2'b00) || mem_wr !== dma_wr || mem_addr !== dma_addr) begin
                n_bad++; $display("FAIL runoff_mem c=%0d got rd=%b wr=%b addr=%h want %b %b %h", c, mem_rd, mem_wr, mem_addr, (dma_rd && dma_wr == 2'b00), dma_wr, dma_addr);
            end
            @(negedge clk);
        end
        // Two steals were used before the halt; only two more remain.
        run_in = 1'b1; cpu_wr = 2'b00; cpu_rd = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_cmp++;
            if (dma_ack !== (c <= 2) || cpu_run !== (c == 3)) begin
                n_bad++; $display("FAIL runoff_post c=%0d got ack=%b run=%b want %b %b", c, dma_ack, cpu_run, (c <= 2), (c == 3));
            end
            @(negedge clk);
        end
        dma_req = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_byte_write;
        dma_req = 1'b1; dma_rd = 1'b0; dma_wr = 2'b01; dma_wdata = 16'($urandom); dma_addr = 16'($urandom);
        #1;
        n_cmp++;
        if (dma_ack !== 1'b1 || mem_wr !== 2'b01 || mem_wdata !== dma_wdata) begin
            n_bad++; $display("FAIL byte_dma got ack=%b wr=%b data=%h want 1 01 %h", dma_ack, mem_wr, mem_wdata, dma_wdata);
        end
        @(negedge clk);
        dma_req = 1'b0; cpu_wr = 2'b10; cpu_dout = 16'($urandom);
        #1;
        n_cmp++;
        if (dma_ack !== 1'b0 || mem_wr !== 2'b10 || mem_wdata !== cpu_dout) begin
            n_bad++; $display("FAIL byte_cpu got ack=%b wr=%b data=%h want 0 10 %h", dma_ack, mem_wr, mem_wdata, cpu_dout);
        end
        @(negedge clk);
        cpu_wr = 2'b00; dma_req = 1'b1; dma_rd = 1'b0; dma_wr = 2'b00;
        #1;
        n_cmp++;
        if (dma_ack !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 2'b00) begin
            n_bad++; $display("FAIL noop_dma got ack=%b rd=%b wr=%b want 1 0 00", dma_ack, mem_rd, mem_wr);
        end
        @(negedge clk);
        dma_req = 1'b0;
    endtask

    task automatic test_reset_in_burst;
        dma_req = 1'b1; dma_rd = 1'b1; cpu_rd = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            #1;
            n_cmp++;
            if (dma_ack !== (c >= 9)) begin
                n_bad++; $display("FAIL rstb_pre c=%0d got ack=%b want %b", c, dma_ack, (c >= 9));
            end
            @(negedge clk);
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (dma_ack !== 1'b0 || cpu_run !== 1'b0) begin
                n_bad++; $display("FAIL rstb_during got ack=%b run=%b want 0 0", dma_ack, cpu_run);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #1;
            n_cmp++;
            if (dma_ack !== (c == 9) || cpu_run !== (c != 9)) begin
                n_bad++; $display("FAIL rstb_post c=%0d got ack=%b run=%b want %b %b", c, dma_ack, cpu_run, (c == 9), (c != 9));
            end
            @(negedge clk);
        end
        dma_req = 1'b0; cpu_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic prev_ack = 1'b0;
        int   stall = 0;
        for (int c = 0; c < 600; c++) begin
            int kind;
            reset  = ($urandom_range(0, 99) == 0);
            run_in = ($urandom_range(0, 7) != 0);
            kind   = int'($urandom_range(0, 3));
            cpu_rd = (kind == 1 || kind == 3);
            cpu_wr = (kind == 2) ? 2'($urandom_range(1, 3)) : 2'b00;
            cpu_addr = 16'($urandom); cpu_dout = 16'($urandom); mem_rdata = 16'($urandom);
            if (!dma_req || prev_ack) begin
                dma_req = ($urandom_range(0, 2) != 0);
                dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
                dma_rd = 1'($urandom); dma_wr = 2'($urandom_range(0, 3));
            end
            #1;
            n_cmp++;
            if (dma_ack !== e_ack || cpu_run !== e_run) begin
                n_bad++; $display("FAIL rand_ctrl c=%0d got ack=%b run=%b want %b %b", c, dma_ack, cpu_run, e_ack, e_run);
            end
            n_cmp++;
            if (mem_rd !== e_mem_rd || mem_wr !== e_mem_wr) begin
                n_bad++; $display("FAIL rand_strobe c=%0d got rd=%b wr=%b want %b %b", c, mem_rd, mem_wr, e_mem_rd, e_mem_wr);
            end
            if (!reset) begin
                n_cmp++;
                if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                    n_bad++; $display("FAIL rand_data c=%0d got addr=%h wdata=%h want %h %h", c, mem_addr, mem_wdata, e_addr, e_wdata);
                end
            end
            n_cmp++;
            if (cpu_din !== mem_rdata || dma_rdata !== mem_rdata) begin
                n_bad++; $display("FAIL rand_rdata c=%0d got %h %h want %h", c, cpu_din, dma_rdata, mem_rdata);
            end
            stall = (!reset && run_in && cpu_run === 1'b0) ? stall + 1 : 0;
            n_cmp++;
            if (stall > BU) begin
                n_bad++; $display("FAIL rand_stall_len c=%0d got %0d want <= %0d", c, stall, BU);
            end
            prev_ack = e_ack;
            @(negedge clk);
        end
        reset = 1'b0; dma_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 2'b00;
    endtask

    initial begin
        reset = 1'b1; run_in = 1'b1;
        cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 2'b00; cpu_dout = '0;
        dma_req = 1'b0; dma_addr = '0; dma_rd = 1'b0; dma_wr = 2'b00; dma_wdata = '0;
        mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_cpu_only();
        test_free_dma();
        test_starvation();
        test_run_off();
        test_byte_write();
        test_reset_in_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit memory port between the b16 cpu and one DMA requester.
- The cpu has no wait input, so the arbiter stalls it by deasserting its run input whenever the DMA owns a cycle the cpu needs.
- Idle cpu cycles (no rd, no wr) are handed to the DMA for free.
- A starvation timer and burst limiter bound latency for both sides.

Parameters:
- l, 16, data/address width.
- WAITMAX, 8, cycles a DMA request may wait before it takes priority (1..255).
- BURST, 4, maximum consecutive stolen (cpu-stalling) DMA cycles before a forced cpu cycle (1..255).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- run_in  in  1  run request from debugger; cpu stalled when 0.
- cpu_run  out  1  run input of cpu.
- cpu_addr  in  l  cpu address.
- cpu_rd  in  1  cpu read strobe.
- cpu_wr  in  2  cpu byte write strobes {hi,lo}.
- cpu_dout  in  l  cpu write data.
- cpu_din  out  l  read data to cpu (= mem_rdata).
- dma_req  in  1  DMA access request; held until dma_ack.
- dma_addr  in  l  DMA address.
- dma_rd  in  1  DMA read (ignored when dma_wr!=0).
- dma_wr  in  2  DMA byte write strobes.
- dma_wdata  in  l  DMA write data.
- dma_ack  out  1  access performed this cycle.
- dma_rdata  out  l  read data (= mem_rdata; valid when dma_ack).
- mem_addr  out  l  memory address.
- mem_rd  out  1  memory read.
- mem_wr  out  2  memory byte writes.
- mem_wdata  out  l  memory write data.
- mem_rdata  in  l  memory read data, combinational, same cycle.

Behaviour:
- Memory is single-cycle: a granted access completes in the cycle it is presented. Mux and ack are combinational from registered state plus inputs.
- cpu_need = cpu_rd | |cpu_wr.
- Grant (one owner per cycle):
  - dma_req & (!cpu_need | !run_in) -> DMA, "free" cycle. cpu_run = run_in.
  - else if dma_req & state==DMA_PRI -> DMA, "stolen" cycle. cpu_run = 0.
  - else -> CPU. cpu_run = run_in; dma_ack = 0.
- On a DMA grant: dma_ack=1 and mem_* come from the dma_* inputs. mem_rd = dma_rd & ~|dma_wr.
- On a CPU grant: mem_* come from the cpu_* inputs, but mem_rd/mem_wr are gated by run_in.
- States: CPU_PRI (reset), DMA_PRI, FORCE_CPU. Counters: wait_cnt 8 bits, burst_cnt 8 bits.
- CPU_PRI:
  - wait_cnt increments each cycle with dma_req & !dma_ack, saturating at 255.
  - wait_cnt clears on dma_ack or !dma_req.
  - When wait_cnt reaches WAITMAX-1 and another wait occurs -> DMA_PRI, burst_cnt=0.
- DMA_PRI:
  - Each stolen cycle increments burst_cnt; free cycles do not count.
  - dma_req=0 -> CPU_PRI, wait_cnt=0.
  - burst_cnt reaches BURST -> FORCE_CPU.
- FORCE_CPU:
  - Exactly one cycle where DMA is granted only if the cycle is free.
  - The cpu is never stalled by the arbiter in this state.
  - Then -> CPU_PRI, wait_cnt=0.
- run_in=0: every cycle is free. DMA is always granted when requesting, and states/counters behave as for free cycles, so no stealing is counted.
- Simultaneous cpu_need and dma_req in CPU_PRI: cpu wins, wait_cnt counts.
- DMA accesses with dma_rd=0 and dma_wr=0 are still acked (no-op), with mem_rd=0 and mem_wr=0.
- While reset=1, and on the cycle after it drops:
  - state=CPU_PRI, counters=0.
  - During reset: cpu_run=0, dma_ack=0, mem_rd=0, mem_wr=0. mem_addr and mem_wdata are don't-care but must hold no X.
  - A DMA request pending across reset is not acked during reset and restarts wait counting afterwards.
- Latency bounds: cpu stalled at most BURST consecutive cycles. A DMA request is acked within WAITMAX+1 cycles while the cpu runs continuously.

Test Plan:
- run_in=1, cpu reads every cycle, dma_req=0 -> cpu_run=1 every cycle, mem_addr=cpu_addr, dma_ack=0, state stays CPU_PRI.
- cpu alternates rd/no-access, DMA write addr=0x0100 data=0xBEEF wr=2'b11 -> ack on the first cpu-idle cycle, mem_wr=2'b11, cpu_run never 0, wait_cnt cleared.
- cpu accesses every cycle, dma_req held with 6 queued reads, WAITMAX=8, BURST=4 -> first ack on cycle 9. Then 4 stolen acks with cpu_run=0. Then 1 cycle cpu_run=1, dma_ack=0 (FORCE_CPU). Then 8 more waits before the next steal.
- run_in=0, dma_req for 10 cycles -> 10 consecutive acks, cpu_run=0, mem_rd/wr from DMA only, burst_cnt stays 0.
- DMA byte write dma_wr=2'b01 with cpu idle -> mem_wr=2'b01. cpu_wr=2'b10 on the next cycle -> mem_wr=2'b10 and mem_wdata=cpu_dout.
- Reset asserted in DMA_PRI with burst_cnt=2 and dma_req=1 -> no ack and cpu_run=0 during reset. After release: CPU_PRI, cpu wins conflicts, DMA acked only after WAITMAX waits again.
